// File: rtl/instr_encoder.sv
// Packs compact instruction commands into RV32I words and streams them into
// instruction memory; holds the core off (prog_done low) until loading ends.
module instr_encoder #(
  parameter int          ADDR_WIDTH = 6,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_kind,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7b5,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [20:0]           in_imm,
  input  logic                  in_last,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  prog_done,
  output logic                  err,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {IDLE, ENC, WRITE, DONE} state_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [20:0] imm;
    logic        last;
  } cmd_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;

  logic [31:0] word;
  logic [1:0]  chk;
  logic        rng12, rng13, misal;

  // Immediate fits 12 (resp. 13) signed bits when the upper bits are all equal.
  assign rng12 = (&cmd_q.imm[20:11]) | ~(|cmd_q.imm[20:11]);
  assign rng13 = (&cmd_q.imm[20:12]) | ~(|cmd_q.imm[20:12]);
  assign misal = ((cmd_q.kind == 3'b011) || (cmd_q.kind == 3'b101)) && cmd_q.imm[0];

  always_comb begin
    word = '0;
    chk  = 2'b00;
    case (cmd_q.kind)
      3'b000: begin
        word = {cmd_q.imm[11:0], cmd_q.rs1, 3'b010, cmd_q.rd, 7'b0000011};
        if (!rng12) chk = 2'b10;
      end
      3'b001: begin
        word = {cmd_q.imm[11:5], cmd_q.rs2, cmd_q.rs1, 3'b010, cmd_q.imm[4:0], 7'b0100011};
        if (!rng12) chk = 2'b10;
      end
      3'b010: word = {1'b0, cmd_q.f7b5, 5'b00000, cmd_q.rs2, cmd_q.rs1, cmd_q.funct3,
                      cmd_q.rd, 7'b0110011};
      3'b011: begin
        word = {cmd_q.imm[12], cmd_q.imm[10:5], cmd_q.rs2, cmd_q.rs1, 3'b000,
                cmd_q.imm[4:1], cmd_q.imm[11], 7'b1100011};
        if (misal) chk = 2'b11;
        else if (!rng13) chk = 2'b10;
      end
      3'b100: begin
        word = {cmd_q.imm[11:0], cmd_q.rs1, cmd_q.funct3, cmd_q.rd, 7'b0010011};
        if (!rng12) chk = 2'b10;
      end
      3'b101: begin
        word = {cmd_q.imm[20], cmd_q.imm[10:1], cmd_q.imm[11], cmd_q.imm[19:12],
                cmd_q.rd, 7'b1101111};
        if (misal) chk = 2'b11;
      end
      default: chk = 2'b01;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    code_d    = code_q;
    case (state_q)
      IDLE: if (in_valid) begin
        cmd_d   = '{in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, in_last};
        state_d = ENC;
      end
      ENC: if (chk != 2'b00) begin
        err_d = 1'b1;
        if (code_q == 2'b00) code_d = chk;
        state_d = cmd_q.last ? DONE : IDLE;
      end else begin
        wr_data_d = word;
        state_d   = WRITE;
      end
      WRITE: if ((&wr_addr_q) || cmd_q.last) begin
        state_d = DONE;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
        state_d   = IDLE;
      end
      default: state_d = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      wr_addr_q <= BASE;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign wr_en     = (state_q == WRITE);
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign prog_done = (state_q == DONE);
  assign err       = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench: expected writes are queued at issue and compared as the
// write strobes appear; a second instance covers the narrow address space.
module tb_instr_encoder;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 0;
  logic        reset = 1;
  logic        in_valid1 = 0, in_valid2 = 0;
  logic [2:0]  in_kind = 0, in_funct3 = 0;
  logic        in_funct7b5 = 0, in_last = 0;
  logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [20:0] in_imm = 0;

  logic        in_ready1, wr_en1, prog_done1, err1;
  logic [5:0]  wr_addr1;
  logic [31:0] wr_data1;
  logic [1:0]  err_code1;
  logic        in_ready2, wr_en2, prog_done2, err2;
  logic [1:0]  wr_addr2;
  logic [31:0] wr_data2;
  logic [1:0]  err_code2;

  int checks = 0;
  int failures = 0;
  wr_t sb[$];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(6)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .prog_done(prog_done1),
    .err(err1), .err_code(err_code1)
  );

  instr_encoder #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .prog_done(prog_done2),
    .err(err2), .err_code(err_code2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input logic [5:0] a, input logic [31:0] d);
    wr_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL unexpected_write observed addr=%0d data=0x%0h expected=no write", a, d);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("wr_addr", {26'b0, a}, {26'b0, e.addr});
      check("wr_data", d, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en1) mon(wr_addr1, wr_data1);
    if (wr_en2) mon({4'b0, wr_addr2}, wr_data2);
  end

  task automatic expect_wr(input logic [5:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Waits (bounded) for ready, then presents one command for a single edge.
  task automatic send(input bit sel, input logic [2:0] k, input logic [2:0] f3,
                      input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [20:0] imm, input logic last);
    int n = 0;
    @(negedge clk);
    while (!(sel ? in_ready2 : in_ready1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", {31'b0, sel ? in_ready2 : in_ready1}, 32'd1);
    in_kind = k; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid1 = !sel;
    in_valid2 = sel;
    @(posedge clk);
    #1;
    in_valid1 = 0;
    in_valid2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready1}, 0);
    check("rst_wr_en", {31'b0, wr_en1}, 0);
    check("rst_wr_addr", {26'b0, wr_addr1}, 0);
    check("rst_wr_data", wr_data1, 0);
    check("rst_prog_done", {31'b0, prog_done1}, 0);
    check("rst_err", {30'b0, err_code1, err1} , 0);
    reset = 0;

    // add x3,x1,x2 with strobe timing
    expect_wr(6'd0, 32'h002081B3);
    send(0, 3'b010, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
    @(negedge clk);
    check("enc_no_strobe", {31'b0, wr_en1}, 0);
    @(negedge clk);
    check("write_strobe", {31'b0, wr_en1}, 1);
    @(negedge clk);
    check("strobe_one_cycle", {31'b0, wr_en1}, 0);
    check("ready_after_3", {31'b0, in_ready1}, 1);
    check("addr_incr", {26'b0, wr_addr1}, 1);

    // lw / sw back to back, then beq / jal
    do_reset();
    expect_wr(6'd0, 32'h00812283);
    send(0, 3'b000, 3'b000, 1'b0, 5'd5, 5'd2, 5'd0, 21'd8, 1'b0);
    expect_wr(6'd1, 32'h00512623);
    send(0, 3'b001, 3'b000, 1'b0, 5'd0, 5'd2, 5'd5, 21'd12, 1'b0);
    expect_wr(6'd2, 32'hFE208CE3);
    send(0, 3'b011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1FFFF8, 1'b0);
    expect_wr(6'd3, 32'hFFDFF06F);
    send(0, 3'b101, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 21'h1FFFFC, 1'b0);
    repeat (3) @(negedge clk);
    check("addr_after_4", {26'b0, wr_addr1}, 4);
    check("no_done_yet", {31'b0, prog_done1}, 0);

    // errors: illegal kind, then misaligned beq keeps first code
    send(0, 3'b111, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 21'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("illegal_err", {31'b0, err1}, 1);
    check("illegal_code", {30'b0, err_code1}, 1);
    check("illegal_addr_hold", {26'b0, wr_addr1}, 4);
    check("illegal_back_idle", {31'b0, in_ready1}, 1);
    send(0, 3'b011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 21'd5, 1'b0);
    repeat (3) @(negedge clk);
    check("first_code_kept", {30'b0, err_code1}, 1);
    check("misal_addr_hold", {26'b0, wr_addr1}, 4);

    // range error after reset, then addi at the -2048 boundary still encodes
    do_reset();
    send(0, 3'b000, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd4096, 1'b0);
    repeat (3) @(negedge clk);
    check("range_code", {30'b0, err_code1}, 2);
    check("range_addr_hold", {26'b0, wr_addr1}, 0);
    expect_wr(6'd0, 32'h80000093);
    send(0, 3'b100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'h1FF800, 1'b0);
    repeat (3) @(negedge clk);

    // in_last on the second command
    do_reset();
    expect_wr(6'd0, 32'h002081B3);
    send(0, 3'b010, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
    expect_wr(6'd1, 32'h00108093);
    send(0, 3'b100, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 21'd1, 1'b1);
    repeat (3) @(negedge clk);
    check("last_done", {31'b0, prog_done1}, 1);
    check("last_addr", {26'b0, wr_addr1}, 1);
    in_valid1 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("done_ready_low", {31'b0, in_ready1}, 0);
    end
    in_valid1 = 0;
    check("done_sticky", {31'b0, prog_done1}, 1);

    // reset while in WRITE
    do_reset();
    send(0, 3'b110, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 21'd0, 1'b0);
    expect_wr(6'd0, 32'h002081B3);
    send(0, 3'b010, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_abort_err", {31'b0, err1}, 1);
    expect_wr(6'd1, 32'h00108093);
    send(0, 3'b100, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 21'd1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check("abort_wr_en", {31'b0, wr_en1}, 0);
    check("abort_addr", {26'b0, wr_addr1}, 0);
    check("abort_err", {31'b0, err1}, 0);
    check("abort_code", {30'b0, err_code1}, 0);
    check("abort_done", {31'b0, prog_done1}, 0);
    check("abort_ready_in_rst", {31'b0, in_ready1}, 0);
    reset = 0;
    @(negedge clk);
    check("abort_ready_after", {31'b0, in_ready1}, 1);

    // narrow instance ends at the last address without in_last
    do_reset();
    expect_wr(6'd0, 32'h00000093);
    send(1, 3'b100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd0, 1'b0);
    expect_wr(6'd1, 32'h00100093);
    send(1, 3'b100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd1, 1'b0);
    expect_wr(6'd2, 32'h00200093);
    send(1, 3'b100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd2, 1'b0);
    check("wrap_not_done", {31'b0, prog_done2}, 0);
    expect_wr(6'd3, 32'h00300093);
    send(1, 3'b100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd3, 1'b0);
    repeat (3) @(negedge clk);
    check("full_done", {31'b0, prog_done2}, 1);
    check("full_addr", {30'b0, wr_addr2}, 3);
    check("full_ready", {31'b0, in_ready2}, 0);

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
